// File: rtl/saed32_mem_pkg.sv
// Shared constants for the SAED32 64x16 FIFO controller and its output buffer.
package saed32_mem_pkg;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 6;
   localparam int DEPTH   = 64;
   localparam int OBUF_N  = 2;
   localparam int COUNT_W = 7;

   // Macro occupancy value that blocks further pushes.
   localparam logic [COUNT_W-1:0] MEM_FULL     = 7'(DEPTH);
   // A prefetch may be issued only while the buffer plus in-flight reads stay below this.
   localparam logic [2:0]         OBUF_LIMIT   = 3'(OBUF_N);
   // Port-0 write mask: every bit written on every write.
   localparam logic [DATA_W-1:0]  WEM_ALL_ONES = {DATA_W{1'b1}};

endpackage

// File: rtl/saed32_fifo_obuf.sv
// Two-entry registered output buffer: entry 0 is always the head word.
// Absorbs the macro's one-cycle read latency so pops can run every cycle.
module saed32_fifo_obuf
   import saed32_mem_pkg::*;
(
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              clear,
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        obuf_cnt
);

   logic [DATA_W-1:0] ent0_r;
   logic [DATA_W-1:0] ent1_r;
   logic [1:0]        cnt_r;
   logic [DATA_W-1:0] ent0_s;
   logic [DATA_W-1:0] ent1_s;
   logic [1:0]        cnt_s;

   // Next-state of the two entries and the occupancy for fill/pop/clear.
   always_comb begin
      ent0_s = ent0_r;
      ent1_s = ent1_r;
      cnt_s  = cnt_r;
      if (clear) begin
         ent0_s = {DATA_W{1'b0}};
         ent1_s = {DATA_W{1'b0}};
         cnt_s  = 2'd0;
      end else begin
         case ({fill, pop})
            2'b10: begin
               case (cnt_r)
                  2'd0: begin
                     ent0_s = fill_data;
                     cnt_s  = 2'd1;
                  end
                  2'd1: begin
                     ent1_s = fill_data;
                     cnt_s  = 2'd2;
                  end
                  default: begin
                     cnt_s = cnt_r;
                  end
               endcase
            end
            2'b01: begin
               ent0_s = ent1_r;
               cnt_s  = cnt_r - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the filled word lands behind whatever stays.
               if (cnt_r == 2'd1) begin
                  ent0_s = fill_data;
               end else begin
                  ent0_s = ent1_r;
                  ent1_s = fill_data;
               end
            end
            default: begin
               cnt_s = cnt_r;
            end
         endcase
      end
   end

   // Buffer entry and occupancy registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ent0_r <= {DATA_W{1'b0}};
         ent1_r <= {DATA_W{1'b0}};
         cnt_r  <= 2'd0;
      end else begin
         ent0_r <= ent0_s;
         ent1_r <= ent1_s;
         cnt_r  <= cnt_s;
      end
   end

   assign head_data = ent0_r;
   assign obuf_cnt  = cnt_r;

endmodule

// File: rtl/saed32_64x16_fifo_ctrl.sv
// FIFO controller for one wrap_saed32_64x16 dual-port macro.
// Port 0 writes pushed words, port 1 prefetches into a 2-entry output buffer.
module saed32_64x16_fifo_ctrl
   import saed32_mem_pkg::*;
(
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [COUNT_W-1:0] count,
   output logic [ADDR_W-1:0]  mem_A0,
   output logic [DATA_W-1:0]  mem_D0,
   output logic               mem_WE0,
   output logic               mem_CE0,
   output logic [DATA_W-1:0]  mem_WEM0,
   output logic [ADDR_W-1:0]  mem_A1,
   output logic               mem_CE1,
   output logic               mem_WE1,
   output logic [DATA_W-1:0]  mem_D1,
   output logic [DATA_W-1:0]  mem_WEM1,
   input  logic [DATA_W-1:0]  mem_Q1
);

   logic [ADDR_W-1:0]  wptr_r;
   logic [ADDR_W-1:0]  rptr_r;
   logic [COUNT_W-1:0] mem_cnt_r;
   logic [COUNT_W-1:0] count_r;
   logic               rd_inflight_r;

   logic [1:0]         obuf_cnt_s;
   logic [DATA_W-1:0]  head_s;
   logic               in_ready_s;
   logic               push_s;
   logic               pop_s;
   logic               issue_s;
   logic               fill_s;
   logic [2:0]         proj_s;

   // Handshake decode and prefetch decision; flush blocks push, pop and new reads.
   always_comb begin
      in_ready_s = (mem_cnt_r != MEM_FULL) && !flush;
      push_s     = in_valid && in_ready_s;
      pop_s      = (obuf_cnt_s != 2'd0) && out_ready && !flush;
      // Buffer occupancy after this cycle's pop once the in-flight read lands.
      proj_s     = {1'b0, obuf_cnt_s} + {2'b00, rd_inflight_r} - {2'b00, pop_s};
      issue_s    = (mem_cnt_r != 7'd0) && !flush && (proj_s < OBUF_LIMIT);
      // Read data returning during a flush belongs to the discarded contents.
      fill_s     = rd_inflight_r && !flush;
   end

   // Pointers, macro occupancy, in-flight read flag and the total word count.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wptr_r        <= {ADDR_W{1'b0}};
         rptr_r        <= {ADDR_W{1'b0}};
         mem_cnt_r     <= 7'd0;
         rd_inflight_r <= 1'b0;
         count_r       <= 7'd0;
      end else if (flush) begin
         wptr_r        <= {ADDR_W{1'b0}};
         rptr_r        <= {ADDR_W{1'b0}};
         mem_cnt_r     <= 7'd0;
         rd_inflight_r <= 1'b0;
         count_r       <= 7'd0;
      end else begin
         wptr_r        <= wptr_r + {5'd0, push_s};
         rptr_r        <= rptr_r + {5'd0, issue_s};
         mem_cnt_r     <= mem_cnt_r + {6'd0, push_s} - {6'd0, issue_s};
         rd_inflight_r <= issue_s;
         // Issue and fill only move words between stages, so only push/pop change the total.
         count_r       <= count_r + {6'd0, push_s} - {6'd0, pop_s};
      end
   end

   saed32_fifo_obuf u_obuf (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .clear     (flush),
      .fill      (fill_s),
      .fill_data (mem_Q1),
      .pop       (pop_s),
      .head_data (head_s),
      .obuf_cnt  (obuf_cnt_s)
   );

   assign in_ready  = in_ready_s;
   assign out_valid = (obuf_cnt_s != 2'd0);
   assign out_data  = head_s;
   assign count     = count_r;

   assign mem_A0    = wptr_r;
   assign mem_D0    = in_data;
   assign mem_WE0   = push_s;
   assign mem_CE0   = push_s;
   assign mem_WEM0  = WEM_ALL_ONES;

   assign mem_A1    = rptr_r;
   assign mem_CE1   = issue_s;
   assign mem_WE1   = 1'b0;
   assign mem_D1    = {DATA_W{1'b0}};
   assign mem_WEM1  = {DATA_W{1'b0}};

endmodule

// File: tb/tb_saed32_64x16_fifo_ctrl.sv
// Self-checking bench for saed32_64x16_fifo_ctrl with a behavioural macro model.
module tb_saed32_64x16_fifo_ctrl;

   logic        CLK;
   logic        RSTN;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [6:0]  count;
   logic [5:0]  mem_A0;
   logic [15:0] mem_D0;
   logic        mem_WE0;
   logic        mem_CE0;
   logic [15:0] mem_WEM0;
   logic [5:0]  mem_A1;
   logic        mem_CE1;
   logic        mem_WE1;
   logic [15:0] mem_D1;
   logic [15:0] mem_WEM1;
   logic [15:0] mem_Q1;

   saed32_64x16_fifo_ctrl dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .mem_A0    (mem_A0),
      .mem_D0    (mem_D0),
      .mem_WE0   (mem_WE0),
      .mem_CE0   (mem_CE0),
      .mem_WEM0  (mem_WEM0),
      .mem_A1    (mem_A1),
      .mem_CE1   (mem_CE1),
      .mem_WE1   (mem_WE1),
      .mem_D1    (mem_D1),
      .mem_WEM1  (mem_WEM1),
      .mem_Q1    (mem_Q1)
   );

   // Clock: 10 ns period, first rising edge at 5 ns.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Behavioural macro: synchronous write on port 0, registered read on port 1.
   logic [15:0] macro_mem [64];
   always @(posedge CLK) begin
      if (mem_CE0 && mem_WE0) macro_mem[mem_A0] <= mem_D0;
      if (mem_CE1) mem_Q1 <= macro_mem[mem_A1];
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   int          n_cmp;
   int          n_err;
   logic [15:0] sb_q[$];
   int          m_cnt;
   logic [5:0]  m_wptr;
   logic [5:0]  m_rptr;
   int          pop_total;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Per-cycle monitor at the falling edge: scoreboard, count model, address model.
   task automatic monitor();
      logic        push_acc;
      logic        pop_acc;
      logic [15:0] exp_w;
      push_acc = in_valid && in_ready && !flush;
      pop_acc  = out_valid && out_ready && !flush;
      chk("count", {25'd0, count}, m_cnt);
      chk("we0_vs_handshake", {31'd0, mem_WE0}, {31'd0, push_acc});
      if (m_cnt == 0) begin
         chk("empty_out_valid", {31'd0, out_valid}, 32'd0);
         chk("empty_ce1", {31'd0, mem_CE1}, 32'd0);
      end
      if (flush) chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      if (mem_WE0) begin
         chk("a0", {26'd0, mem_A0}, {26'd0, m_wptr});
         chk("d0", {16'd0, mem_D0}, {16'd0, in_data});
         chk("ce0", {31'd0, mem_CE0}, 32'd1);
      end
      if (mem_CE1) begin
         chk("a1", {26'd0, mem_A1}, {26'd0, m_rptr});
         m_rptr = m_rptr + 6'd1;
      end
      if (pop_acc) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got %h expected no output", out_data);
         end else begin
            exp_w = sb_q.pop_front();
            chk("out_data", {16'd0, out_data}, {16'd0, exp_w});
         end
         pop_total++;
      end
      if (flush) begin
         sb_q.delete();
         m_cnt  = 0;
         m_wptr = 6'd0;
         m_rptr = 6'd0;
      end else begin
         if (push_acc) begin
            sb_q.push_back(in_data);
            m_wptr = m_wptr + 6'd1;
            m_cnt++;
         end
         if (pop_acc) m_cnt--;
      end
   endtask

   // One cycle: monitor at the falling edge, return 1 ns after the next rising edge.
   task automatic tick();
      @(negedge CLK);
      monitor();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_clear();
      sb_q.delete();
      m_cnt  = 0;
      m_wptr = 6'd0;
      m_rptr = 6'd0;
   endtask

   task automatic drain(input string nm, input int budget);
      int k;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      k = 0;
      while ((sb_q.size() != 0) && (k < budget)) begin
         tick();
         k++;
      end
      chk({nm, "_drain_done"}, sb_q.size(), 32'd0);
   endtask

   typedef struct {
      logic        iv;
      logic [15:0] id;
      logic        ordy;
      logic        e_irdy;
      logic        e_ce0;
      logic [5:0]  e_a0;
      logic        e_ce1;
      logic [5:0]  e_a1;
      logic        e_ov;
      logic        chk_od;
      logic [15:0] e_od;
      logic [6:0]  e_cnt;
   } vec_t;

   vec_t vt[10];

   initial begin
      int pops_before;
      int k;
      n_cmp     = 0;
      n_err     = 0;
      pop_total = 0;
      model_clear();
      RSTN      = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      out_ready = 1'b0;

      //          iv    id        ordy  irdy  ce0   a0     ce1   a1     ov    chkod od        cnt
      for (int i = 0; i < 5; i++)
         vt[i] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 16'h0000, 7'd0};
      vt[5] = '{1'b1, 16'hA5A5, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 16'h0000, 7'd0};
      vt[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 1'b0, 16'h0000, 7'd1};
      vt[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0000, 7'd1};
      vt[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1, 16'hA5A5, 7'd1};
      vt[9] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 16'h0000, 7'd0};

      // Reset values while RSTN is held low.
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {16'd0, out_data}, 32'd0);
      chk("rst_count", {25'd0, count}, 32'd0);
      chk("rst_ce0", {31'd0, mem_CE0}, 32'd0);
      chk("rst_ce1", {31'd0, mem_CE1}, 32'd0);
      chk("wem0_const", {16'd0, mem_WEM0}, 32'h0000FFFF);
      chk("we1_const", {31'd0, mem_WE1}, 32'd0);
      chk("d1_const", {16'd0, mem_D1}, 32'd0);
      chk("wem1_const", {16'd0, mem_WEM1}, 32'd0);
      RSTN = 1'b1;

      // Table: 5 idle cycles, then a single word through the pipeline.
      for (int i = 0; i < 10; i++) begin
         in_valid  = vt[i].iv;
         in_data   = vt[i].id;
         out_ready = vt[i].ordy;
         #2;
         chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].e_irdy});
         chk($sformatf("vec%0d_ce0", i), {31'd0, mem_CE0}, {31'd0, vt[i].e_ce0});
         if (vt[i].e_ce0) chk($sformatf("vec%0d_a0", i), {26'd0, mem_A0}, {26'd0, vt[i].e_a0});
         chk($sformatf("vec%0d_ce1", i), {31'd0, mem_CE1}, {31'd0, vt[i].e_ce1});
         if (vt[i].e_ce1) chk($sformatf("vec%0d_a1", i), {26'd0, mem_A1}, {26'd0, vt[i].e_a1});
         chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].e_ov});
         if (vt[i].chk_od) chk($sformatf("vec%0d_out_data", i), {16'd0, out_data}, {16'd0, vt[i].e_od});
         chk($sformatf("vec%0d_count", i), {25'd0, count}, {25'd0, vt[i].e_cnt});
         tick();
      end

      // Fill to 66 words with the output stalled, then drain through the pointer wrap.
      pops_before = pop_total;
      out_ready = 1'b0;
      for (int i = 0; i < 66; i++) begin
         in_valid = 1'b1;
         in_data  = 16'(i);
         #1;
         chk($sformatf("full_ready_w%0d", i), {31'd0, in_ready}, 32'd1);
         tick();
      end
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      repeat (5) tick();
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_count", {25'd0, count}, 32'd66);
      drain("full", 150);
      chk("full_pops", pop_total - pops_before, 32'd66);
      chk("full_after_ov", {31'd0, out_valid}, 32'd0);
      chk("full_after_count", {25'd0, count}, 32'd0);

      // Streaming: 200 words pushed back-to-back with out_ready held high.
      pops_before = pop_total;
      out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h4000 + 16'(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      chk("stream_pops_on_time", pop_total - pops_before, 32'd200);
      chk("stream_end_count", {25'd0, count}, 32'd0);

      // Flush with a read in flight and count=10.
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h0100 + 16'(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      in_valid  = 1'b1;
      in_data   = 16'h2000;
      out_ready = 1'b1;
      #1;
      chk("pre_flush_issue", {31'd0, mem_CE1}, 32'd1);
      tick();
      in_valid = 1'b0;
      flush    = 1'b1;
      #1;
      chk("flush_cycle_count", {25'd0, count}, 32'd10);
      tick();
      flush = 1'b0;
      #1;
      chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("post_flush_count", {25'd0, count}, 32'd0);
      repeat (3) tick();
      chk("post_flush_no_stale", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      in_data  = 16'h1234;
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && (k < 20)) begin
         tick();
         k++;
      end
      chk("post_flush_first_valid", {31'd0, out_valid}, 32'd1);
      chk("post_flush_first_word", {16'd0, out_data}, 32'h00001234);
      drain("flush", 20);

      // Async reset pulse between edges in the middle of a stream.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 16'h7000 + 16'(i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      RSTN = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_out_data", {16'd0, out_data}, 32'd0);
      chk("arst_count", {25'd0, count}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_ce1", {31'd0, mem_CE1}, 32'd0);
      RSTN = 1'b1;
      model_clear();
      tick();
      tick();
      in_valid  = 1'b1;
      in_data   = 16'h5A5A;
      out_ready = 1'b1;
      #1;
      chk("arst_a0_restart", {26'd0, mem_A0}, 32'd0);
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && (k < 20)) begin
         tick();
         k++;
      end
      chk("arst_first_word", {16'd0, out_data}, 32'h00005A5A);
      drain("arst", 20);
      tick();
      chk("final_count", {25'd0, count}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/saed32_64x16_fifo_ctrl.md
Name: saed32_64x16_fifo_ctrl

Overview:
- Synchronous FIFO controller that drives one wrap_saed32_64x16 dual-port macro: port 0 is write-only, port 1 is read-only.
- Sits directly upstream of the macro. It converts a valid/ready push/pop stream into macro control signals.
- Hides the macro's 1-cycle read latency with a 2-entry output buffer, so pops run at full throughput.

Parameters:
- DATA_W, 16, word width; must match macro D/Q width.
- ADDR_W, 6, macro address width.
- DEPTH, 64, macro entries (2**ADDR_W).
- OBUF_N, 2, output buffer entries (fixed; not user-tunable).

Ports:
- CLK  in  1  single clock; also drives the macro CLK.
- RSTN  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all FIFO state.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid & in_ready.
- in_data  in  DATA_W  push data.
- out_valid  out  1  out_data holds the head word.
- out_ready  in  1  pop when out_valid & out_ready.
- out_data  out  DATA_W  head word, registered.
- count  out  7  total words held: macro + in-flight read + output buffer; range 0..66.
- mem_A0  out  ADDR_W  write address (wptr).
- mem_D0  out  DATA_W  write data (= in_data).
- mem_WE0  out  1  write enable.
- mem_CE0  out  1  port-0 enable.
- mem_WEM0  out  DATA_W  write mask; constant all-ones.
- mem_A1  out  ADDR_W  read address (rptr).
- mem_CE1  out  1  port-1 enable.
- mem_WE1  out  1  constant 0.
- mem_D1  out  DATA_W  constant 0.
- mem_WEM1  out  DATA_W  constant 0.
- mem_Q1  in  DATA_W  macro read data; valid the cycle after mem_CE1=1.

Behaviour:
- Reset (RSTN=0, async):
  - wptr=rptr=0, mem_cnt=0, rd_inflight=0, obuf empty.
  - Outputs: out_valid=0, out_data=0, count=0, mem_CE0=mem_WE0=mem_CE1=0, in_ready=1.
  - Reset asserted mid-operation discards all contents and any in-flight read.
- Push:
  - in_ready = (mem_cnt != 64) & ~flush.
  - On accept: mem_CE0=mem_WE0=1, mem_A0=wptr, mem_D0=in_data. wptr increments mod 64 (6-bit natural wrap).
  - CE0/WE0 are combinational from in_valid & in_ready; 0 otherwise.
- Prefetch read:
  - Issue when mem_cnt>0 & ~flush & (obuf_cnt + rd_inflight - pop) < 2.
  - Issue drives mem_CE1=1, mem_A1=rptr. rptr increments mod 64; rd_inflight<=1.
  - Next cycle, mem_Q1 is written into the obuf tail; rd_inflight<=0 unless a new read is issued.
- No address collision:
  - A read requires mem_cnt>0 and a write requires mem_cnt<64, so a same-cycle read and write never share an address.
  - A word written at edge N is readable from cycle N+1.
- mem_cnt update: mem_cnt += push - issue (both may occur in the same cycle).
- Output:
  - out_valid = obuf_cnt>0. out_data = obuf head register.
  - A pop and a fill in the same cycle are allowed; the buffer never overflows by construction.
- Latency: push accepted in cycle N on an empty FIFO -> read issued N+1 -> mem_Q1 N+2 -> out_valid=1 in N+3.
- Throughput: 1 push and 1 pop per cycle sustained.
- count = mem_cnt + rd_inflight + obuf_cnt, registered, updated each edge.
- flush: at the next edge, pointers, counts, rd_inflight and obuf clear; out_valid=0.
  - A Q1 returning in the cycle after the flush is dropped.
  - flush has priority over push and pop: in_ready=0 during flush, and pops are ignored.
- Full: mem_cnt=64 -> in_ready=0. Up to 66 words are held in total.
- Empty: mem_CE1 stays 0; out_valid falls after the last pop.

Decomposition:
- Package saed32_mem_pkg: DATA_W, ADDR_W, DEPTH, OBUF_N, COUNT_W=7, constant WEM_ALL_ONES.
- Sub-module saed32_fifo_obuf: 2-entry registered output buffer.
  - Inputs: fill strobe + data, pop, clear.
  - Outputs: head data, obuf_cnt.
- The top module holds the pointers, mem_cnt, rd_inflight and the macro-side outputs.

Test Plan:
- Reset then idle 5 cycles -> in_ready=1, out_valid=0, count=0, mem_CE0=mem_CE1=0 throughout.
- Push 0xA5A5 at cycle 0 with out_ready=1 -> mem_A0=0 WE0=1 at cycle 0; mem_CE1=1 A1=0 at cycle 1; out_valid=1 with out_data=0xA5A5 at cycle 3; count returns to 0 after the pop.
- Push 66 words 0x0000..0x0041 with out_ready=0 -> in_ready drops after word 65 (0x0041); count=66. Then drain with out_ready=1 -> 66 in-order words, wptr/rptr wrap 63->0 observed.
- Continuous push and pop of 200 words, out_ready=1 -> 1 word/cycle after 3-cycle startup, data in order, count steady at 2 or 3.
- flush asserted while a read is in flight with count=10 -> next cycle count=0, out_valid=0; the stale mem_Q1 is not emitted; the next pushed 0x1234 is the first word out.
- RSTN pulsed low mid-stream for 1 ns between edges -> outputs return to reset values immediately; after release the FIFO behaves as empty.
